// File: rtl/spike_injector.sv
// Spike packet injector: buffers 32-bit packets in a small FIFO and serialises them
// MSB-first into flits for a router local port, with backpressure and an idle gap after each tail.
module spike_injector #(
    parameter int PACKET_SIZE = 32,
    parameter int FLIT_WIDTH  = 4,
    parameter int DEPTH_LOG2  = 3,
    parameter int AF_LEVEL    = 6,
    parameter int GAP_CYCLES  = 4
) (
    input  logic                   neu_clk,
    input  logic                   rst_n,
    input  logic                   write_req,
    input  logic [PACKET_SIZE-1:0] spike_packet,
    input  logic                   router_full,
    output logic                   full,
    output logic                   almost_full,
    output logic                   busy,
    output logic                   flit_valid,
    output logic [FLIT_WIDTH-1:0]  flit_out,
    output logic                   head_flit,
    output logic                   tail_flit,
    output logic [7:0]             drop_count,
    output logic [15:0]            sent_count
);
    localparam int NFLIT = PACKET_SIZE / FLIT_WIDTH;
    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;
    localparam int IW    = (NFLIT > 1) ? $clog2(NFLIT) : 1;
    localparam int GW    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [IW-1:0] LAST_IDX  = IW'(NFLIT - 1);
    localparam logic [GW-1:0] LAST_GAP  = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] AF_CNT    = CW'(AF_LEVEL);

    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

    state_t                  state_reg, state_next;
    logic [PACKET_SIZE-1:0]  mem [DEPTH];
    logic [DEPTH_LOG2-1:0]   wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0]           count_reg, count_next;
    logic                    full_reg, af_reg;
    logic [PACKET_SIZE-1:0]  shift_reg;
    logic [IW-1:0]           flit_idx_reg;
    logic [GW-1:0]           gap_cnt_reg;
    logic [7:0]              drop_reg;
    logic [15:0]             sent_reg;

    logic push, drop, pop, fifo_empty, flit_fire, last_flit;

    // The registered full flag gates writes, so a pop on the same edge cannot admit one.
    assign push       = write_req & ~full_reg;
    assign drop       = write_req & full_reg;
    assign fifo_empty = (count_reg == '0);
    assign flit_fire  = (state_reg == SHIFT) & ~router_full;
    assign last_flit  = flit_fire & (flit_idx_reg == LAST_IDX);

    always_ff @(posedge neu_clk or negedge rst_n) begin
        if (!rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        pop        = 1'b0;
        unique case (state_reg)
            IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (last_flit) begin
                    if (GAP_CYCLES > 0) begin
                        state_next = GAP;
                    end else if (!fifo_empty) begin
                        pop = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            GAP: begin
                if (gap_cnt_reg == LAST_GAP) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        flit_valid = flit_fire;
        head_flit  = flit_fire & (flit_idx_reg == '0);
        tail_flit  = last_flit;
        busy       = (state_reg != IDLE) | ~fifo_empty;
    end

    always_comb begin
        unique case ({push, pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    // Storage carries no reset; stale entries are unreachable once count is cleared.
    always_ff @(posedge neu_clk) begin
        if (push) mem[wr_ptr_reg] <= spike_packet;
    end

    always_ff @(posedge neu_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            full_reg     <= 1'b0;
            af_reg       <= 1'b0;
            shift_reg    <= '0;
            flit_idx_reg <= '0;
            gap_cnt_reg  <= '0;
            drop_reg     <= '0;
            sent_reg     <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop) begin
                rd_ptr_reg   <= rd_ptr_reg + 1'b1;
                shift_reg    <= mem[rd_ptr_reg];
                flit_idx_reg <= '0;
            end else if (flit_fire) begin
                shift_reg    <= shift_reg << FLIT_WIDTH;
                flit_idx_reg <= flit_idx_reg + 1'b1;
            end
            count_reg <= count_next;
            full_reg  <= (count_next == DEPTH_CNT);
            af_reg    <= (count_next >= AF_CNT);
            if (state_reg == SHIFT && state_next == GAP) gap_cnt_reg <= '0;
            else if (state_reg == GAP)                   gap_cnt_reg <= gap_cnt_reg + 1'b1;
            if (drop && drop_reg != 8'hFF) drop_reg <= drop_reg + 1'b1;
            if (last_flit) sent_reg <= sent_reg + 1'b1;
        end
    end

    assign full        = full_reg;
    assign almost_full = af_reg;
    assign flit_out    = shift_reg[PACKET_SIZE-1 -: FLIT_WIDTH];
    assign drop_count  = drop_reg;
    assign sent_count  = sent_reg;

endmodule

// File: tb/tb_spike_injector.sv
// Directed bench for spike_injector: default-gap instance plus a zero-gap instance.
module tb_spike_injector;
    logic        neu_clk = 1'b0;
    logic        rst_n;
    logic        write_req, router_full;
    logic [31:0] spike_packet;
    logic        full, almost_full, busy, flit_valid, head_flit, tail_flit;
    logic [3:0]  flit_out;
    logic [7:0]  drop_count;
    logic [15:0] sent_count;

    logic        write_req0, router_full0;
    logic [31:0] spike_packet0;
    logic        full0, almost_full0, busy0, flit_valid0, head_flit0, tail_flit0;
    logic [3:0]  flit_out0;
    logic [7:0]  drop_count0;
    logic [15:0] sent_count0;

    int total = 0;
    int bad   = 0;

    always #5 neu_clk = ~neu_clk;

    spike_injector dut (
        .neu_clk(neu_clk), .rst_n(rst_n), .write_req(write_req), .spike_packet(spike_packet),
        .router_full(router_full), .full(full), .almost_full(almost_full), .busy(busy),
        .flit_valid(flit_valid), .flit_out(flit_out), .head_flit(head_flit), .tail_flit(tail_flit),
        .drop_count(drop_count), .sent_count(sent_count)
    );

    spike_injector #(.GAP_CYCLES(0)) dut0 (
        .neu_clk(neu_clk), .rst_n(rst_n), .write_req(write_req0), .spike_packet(spike_packet0),
        .router_full(router_full0), .full(full0), .almost_full(almost_full0), .busy(busy0),
        .flit_valid(flit_valid0), .flit_out(flit_out0), .head_flit(head_flit0), .tail_flit(tail_flit0),
        .drop_count(drop_count0), .sent_count(sent_count0)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge neu_clk);
        #1;
    endtask

    function automatic logic [31:0] pkt_of(input int i);
        return 32'hF0E1_D200 + 32'(i);
    endfunction

    // Receives one packet, optionally stalling the router for stall_len cycles before flit stall_at.
    task automatic recv_pkt(input string tag, input logic [31:0] pkt, input int stall_at,
                            input int stall_len, output int span);
        int w;
        logic [31:0] p;
        w = 0;
        span = 1;
        p = pkt;
        router_full = 1'b0;
        #1;
        while (!flit_valid && w < 20) begin
            step();
            #1;
            w++;
        end
        chk({tag, "_head_seen"}, 32'(flit_valid), 32'd1);
        for (int f = 0; f < 8; f++) begin
            if (f == stall_at) begin
                for (int s = 0; s < stall_len; s++) begin
                    router_full = 1'b1;
                    #1;
                    chk({tag, "_stall_valid"}, 32'(flit_valid), 32'd0);
                    step();
                    span++;
                end
            end
            router_full = 1'b0;
            #1;
            chk({tag, "_valid"}, 32'(flit_valid), 32'd1);
            chk({tag, "_flit"}, 32'(flit_out), 32'(p[31-4*f -: 4]));
            chk({tag, "_head"}, 32'(head_flit), 32'(f == 0));
            chk({tag, "_tail"}, 32'(tail_flit), 32'(f == 7));
            step();
            if (f != 7) span++;
        end
    endtask

    task automatic wait_idle(input string tag);
        int w;
        w = 0;
        while (busy && w < 30) begin
            step();
            w++;
        end
        chk({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int span, nf, ec;
        rst_n = 1'b0;
        write_req = 1'b0; router_full = 1'b0; spike_packet = '0;
        write_req0 = 1'b0; router_full0 = 1'b0; spike_packet0 = '0;
        step();
        step();
        chk("rst_valid", 32'(flit_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_sent", 32'(sent_count), 32'd0);
        rst_n = 1'b1;
        step();

        // 1: single packet, exact latency and gap
        write_req = 1'b1; spike_packet = 32'h1234_5678;
        step();
        write_req = 1'b0;
        #1;
        chk("t1_lat_valid", 32'(flit_valid), 32'd0);
        chk("t1_lat_busy", 32'(busy), 32'd1);
        step();
        for (int i = 0; i < 8; i++) begin
            chk("t1_valid", 32'(flit_valid), 32'd1);
            chk("t1_flit", 32'(flit_out), 32'(i + 1));
            chk("t1_head", 32'(head_flit), 32'(i == 0));
            chk("t1_tail", 32'(tail_flit), 32'(i == 7));
            step();
        end
        for (int i = 0; i < 4; i++) begin
            chk("t1_gap_valid", 32'(flit_valid), 32'd0);
            chk("t1_gap_busy", 32'(busy), 32'd1);
            step();
        end
        chk("t1_sent", 32'(sent_count), 32'd1);
        chk("t1_busy_after", 32'(busy), 32'd0);

        // 2: backpressure for 3 cycles after the second flit
        write_req = 1'b1; spike_packet = 32'hA5A5_A5A5;
        step();
        write_req = 1'b0;
        recv_pkt("t2", 32'hA5A5_A5A5, 2, 3, span);
        chk("t2_span", 32'(span), 32'd11);
        chk("t2_sent", 32'(sent_count), 32'd2);
        wait_idle("t2");

        // 3: fill against a stalled router
        router_full = 1'b1;
        for (int i = 0; i < 10; i++) begin
            write_req = 1'b1; spike_packet = pkt_of(i);
            step();
            ec = (i == 0) ? 1 : ((i > 8) ? 8 : i);
            chk("t3_af", 32'(almost_full), 32'(ec >= 6));
            chk("t3_full", 32'(full), 32'(ec == 8));
        end
        write_req = 1'b0;
        chk("t3_drop", 32'(drop_count), 32'd1);
        chk("t3_valid_stalled", 32'(flit_valid), 32'd0);

        // 4: saturate drop counter, then drain in order
        for (int i = 0; i < 300; i++) begin
            write_req = 1'b1; spike_packet = 32'hDEAD_BEEF;
            step();
        end
        write_req = 1'b0;
        chk("t4_drop_sat", 32'(drop_count), 32'd255);
        chk("t4_full_held", 32'(full), 32'd1);
        for (int i = 0; i < 9; i++) recv_pkt("t4_drain", pkt_of(i), -1, 0, span);
        chk("t4_sent", 32'(sent_count), 32'd11);
        chk("t4_drop_kept", 32'(drop_count), 32'd255);
        wait_idle("t4");

        // 5: reset mid-packet with two more queued
        for (int i = 0; i < 3; i++) begin
            write_req = 1'b1; spike_packet = 32'h7700_0000 + 32'(i);
            step();
        end
        write_req = 1'b0;
        nf = 0;
        for (int c = 0; c < 20 && nf < 3; c++) begin
            #1;
            if (flit_valid) nf++;
            step();
        end
        chk("t5_three_flits", 32'(nf), 32'd3);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_valid", 32'(flit_valid), 32'd0);
        chk("t5_rst_flit", 32'(flit_out), 32'd0);
        chk("t5_rst_busy", 32'(busy), 32'd0);
        chk("t5_rst_sent", 32'(sent_count), 32'd0);
        chk("t5_rst_drop", 32'(drop_count), 32'd0);
        chk("t5_rst_af", 32'(almost_full), 32'd0);
        step();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t5_no_resume", 32'(flit_valid), 32'd0);
            chk("t5_idle", 32'(busy), 32'd0);
        end
        write_req = 1'b1; spike_packet = 32'h5EED_CAFE;
        step();
        write_req = 1'b0;
        recv_pkt("t5_new", 32'h5EED_CAFE, -1, 0, span);
        chk("t5_sent", 32'(sent_count), 32'd1);

        // 6: zero-gap instance, back-to-back packets stream contiguously
        write_req0 = 1'b1; spike_packet0 = 32'h1111_1111;
        step();
        spike_packet0 = 32'h2222_2222;
        step();
        write_req0 = 1'b0;
        nf = 0;
        while (!flit_valid0 && nf < 20) begin
            step();
            nf++;
        end
        for (int i = 0; i < 16; i++) begin
            chk("t6_valid", 32'(flit_valid0), 32'd1);
            chk("t6_flit", 32'(flit_out0), 32'((i < 8) ? 1 : 2));
            chk("t6_head", 32'(head_flit0), 32'(i == 0 || i == 8));
            chk("t6_tail", 32'(tail_flit0), 32'(i == 7 || i == 15));
            step();
        end
        chk("t6_after_valid", 32'(flit_valid0), 32'd0);
        chk("t6_sent", 32'(sent_count0), 32'd2);
        chk("t6_drop", 32'(drop_count0), 32'd0);
        chk("t6_full", 32'({full0, almost_full0, busy0}), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
